// File: rtl/modulo_matriz_varredura_if.sv
// modulo_matriz_varredura_if: write port and scan outputs of the row-scanned matrix.
interface modulo_matriz_varredura_if #(
    parameter int ROWS = 7,
    parameter int COLS = 5
);
    localparam int AW = $clog2(ROWS);
    logic            wr_en;
    logic [AW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic [1:0]      mode;
    logic            scan_en;
    logic [ROWS-1:0] row_out;
    logic [COLS-1:0] col_out;
    logic [AW-1:0]   scan_row;
    logic            frame_done;
    logic            wr_err;
    modport master (
        output wr_en, wr_row, wr_data, mode, scan_en,
        input  row_out, col_out, scan_row, frame_done, wr_err
    );
    modport slave (
        input  wr_en, wr_row, wr_data, mode, scan_en,
        output row_out, col_out, scan_row, frame_done, wr_err
    );
endinterface

// File: rtl/modulo_matriz_varredura.sv
// modulo_matriz_varredura: ROWS x COLS register matrix with editing writes
// and a dwell-timed one-hot row scanner.
module modulo_matriz_varredura #(
    parameter int ROWS  = 7,
    parameter int COLS  = 5,
    parameter int DWELL = 4
) (
    input logic clk,
    input logic clr,
    modulo_matriz_varredura_if.slave bus
);
    localparam int AW  = $clog2(ROWS);
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [COLS-1:0] mem_q [ROWS];
    logic [COLS-1:0] mem_d [ROWS];
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [AW-1:0]   scan_row_q, scan_row_d, nrow;
    logic [ROWS-1:0] row_out_q, row_out_d;
    logic [COLS-1:0] col_out_q, col_out_d, cur;
    logic            frame_done_q, frame_done_d;
    logic            wr_err_q, wr_err_d;
    logic            wr_ok, last;

    always_comb begin
        wr_ok    = 32'(bus.wr_row) < ROWS;
        cur      = wr_ok ? mem_q[bus.wr_row] : '0;
        mem_d    = mem_q;
        wr_err_d = bus.wr_en && !wr_ok;
        if (bus.wr_en) begin
            if (bus.mode == 2'b11)
                mem_d = '{default: '0};
            else if (wr_ok)
                mem_d[bus.wr_row] = bus.mode == 2'b00 ? bus.wr_data :
                                    bus.mode == 2'b01 ? (cur << 1) | (cur >> (COLS - 1)) : '0;
        end
    end

    // Display data always comes from pre-edge storage, so writes show up one edge later.
    always_comb begin
        last         = dcnt_q == DCW'(DWELL - 1);
        nrow         = !last ? scan_row_q :
                       (scan_row_q == AW'(ROWS - 1)) ? '0 : scan_row_q + 1'b1;
        state_d      = bus.scan_en ? SCAN : IDLE;
        dcnt_d       = '0;
        scan_row_d   = '0;
        row_out_d    = '0;
        col_out_d    = '0;
        frame_done_d = 1'b0;
        if (bus.scan_en) begin
            if (state_q == IDLE) begin
                row_out_d = ROWS'(1);
                col_out_d = mem_q[0];
            end else begin
                dcnt_d       = last ? '0 : dcnt_q + 1'b1;
                scan_row_d   = nrow;
                row_out_d    = ROWS'(1) << nrow;
                col_out_d    = mem_q[nrow];
                frame_done_d = last && scan_row_q == AW'(ROWS - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            mem_q        <= '{default: '0};
            dcnt_q       <= '0;
            scan_row_q   <= '0;
            row_out_q    <= '0;
            col_out_q    <= '0;
            frame_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            dcnt_q       <= dcnt_d;
            scan_row_q   <= scan_row_d;
            row_out_q    <= row_out_d;
            col_out_q    <= col_out_d;
            frame_done_q <= frame_done_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign bus.row_out    = row_out_q;
    assign bus.col_out    = col_out_q;
    assign bus.scan_row   = scan_row_q;
    assign bus.frame_done = frame_done_q;
    assign bus.wr_err     = wr_err_q;
endmodule
